// File: rtl/rename_free_list_if.sv
// Rename/commit/free bus between the resolver and the physical-tag free list.
interface rename_free_list_if #(
    parameter int TAG_W = 6,
    parameter int CNT_W = 6
);
    logic [1:0]            alloc_req;
    logic [1:0][TAG_W-1:0] alloc_tag;
    logic                  alloc_grant;
    logic                  stall;
    logic [1:0]            commit_alloc;
    logic [1:0]            free_valid;
    logic [1:0][TAG_W-1:0] free_tag;
    logic                  flush;
    logic [CNT_W-1:0]      free_count;
    logic                  err;

    modport master (
        output alloc_req, commit_alloc, free_valid, free_tag, flush,
        input  alloc_tag, alloc_grant, stall, free_count, err
    );

    modport slave (
        input  alloc_req, commit_alloc, free_valid, free_tag, flush,
        output alloc_tag, alloc_grant, stall, free_count, err
    );
endinterface

// File: rtl/rename_free_list.sv
// Circular physical-tag free list: same-cycle all-or-nothing grant of up to 2 tags, stall when short,
// commit-point rollback on flush. Define RENAME_FREE_LIST_CHECK_EN for the sticky consistency error.
module rename_free_list #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    parameter int TAG_W     = $clog2(PHYS_REGS)
) (
    input  logic            clk,
    input  logic            reset_n,
    rename_free_list_if.slave bus
);
    localparam int DEPTH = PHYS_REGS - ARCH_REGS;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    tag_t mem [DEPTH];
    ptr_t head, c_head, tail;
    cnt_t cnt, c_cnt;

    // DEPTH need not be a power of two, so wrap by compare rather than by truncation.
    function automatic ptr_t ptr_add(input ptr_t p, input logic [1:0] n);
        logic [PTR_W:0] s;
        s = {1'b0, p} + (PTR_W+1)'(n);
        if (s >= (PTR_W+1)'(DEPTH))
            s = s - (PTR_W+1)'(DEPTH);
        return s[PTR_W-1:0];
    endfunction

    logic [1:0] n_req, n_take, n_free, n_commit;
    logic       grant, stall;
    ptr_t       head1, wr1, head_nxt, c_head_nxt;
    cnt_t       cnt_nxt, c_cnt_nxt;
    logic [1:0][TAG_W-1:0] tag;

    assign n_req    = {1'b0, bus.alloc_req[0]}    + {1'b0, bus.alloc_req[1]};
    assign n_free   = {1'b0, bus.free_valid[0]}   + {1'b0, bus.free_valid[1]};
    assign n_commit = {1'b0, bus.commit_alloc[0]} + {1'b0, bus.commit_alloc[1]};

    assign grant  = (n_req != 2'd0) && (cnt >= cnt_t'(n_req)) && !bus.flush;
    assign stall  = (n_req != 2'd0) && (cnt <  cnt_t'(n_req)) && !bus.flush;
    assign n_take = grant ? n_req : 2'd0;

    assign head1 = ptr_add(head, 2'd1);
    assign wr1   = bus.free_valid[0] ? ptr_add(tail, 2'd1) : tail;

    always_comb begin
        tag = '0;
        if (grant) begin
            if (bus.alloc_req[0]) begin
                tag[0] = mem[head];
                if (bus.alloc_req[1])
                    tag[1] = mem[head1];
            end else begin
                tag[1] = mem[head];
            end
        end
    end

    // Flush restores the committed view, including this cycle's commits and frees.
    assign c_head_nxt = ptr_add(c_head, n_commit);
    assign c_cnt_nxt  = c_cnt - cnt_t'(n_commit) + cnt_t'(n_free);
    assign head_nxt   = bus.flush ? c_head_nxt : ptr_add(head, n_take);
    assign cnt_nxt    = bus.flush ? c_cnt_nxt  : cnt - cnt_t'(n_take) + cnt_t'(n_free);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= tag_t'(ARCH_REGS + i);
            head   <= '0;
            c_head <= '0;
            tail   <= '0;
            cnt    <= cnt_t'(DEPTH);
            c_cnt  <= cnt_t'(DEPTH);
        end else begin
            if (bus.free_valid[0])
                mem[tail] <= bus.free_tag[0];
            if (bus.free_valid[1])
                mem[wr1] <= bus.free_tag[1];
            head   <= head_nxt;
            c_head <= c_head_nxt;
            tail   <= ptr_add(tail, n_free);
            cnt    <= cnt_nxt;
            c_cnt  <= c_cnt_nxt;
        end
    end

    assign bus.alloc_grant = grant;
    assign bus.stall       = stall;
    assign bus.alloc_tag   = tag;
    assign bus.free_count  = cnt;

`ifdef RENAME_FREE_LIST_CHECK_EN
    logic err_q;
    logic bad;

    always_comb begin
        bad = ({1'b0, c_cnt} + (CNT_W+1)'(n_free) > (CNT_W+1)'(DEPTH))
           || ({1'b0, c_cnt} < {1'b0, cnt} + (CNT_W+1)'(n_commit))
           || (bus.free_valid[0] && (bus.free_tag[0] == '0))
           || (bus.free_valid[1] && (bus.free_tag[1] == '0))
           || ((&bus.free_valid) && (bus.free_tag[0] == bus.free_tag[1]));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err_q <= 1'b0;
        else
            err_q <= err_q | bad;
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_rename_free_list.sv
// Bench for rename_free_list: DEPTH=32 and DEPTH=16 instances against a queue-based reference model.
module tb_rename_free_list;
    logic clk;
    logic reset_n;

    rename_free_list_if #(.TAG_W(6), .CNT_W(6)) bus0 ();
    rename_free_list_if #(.TAG_W(6), .CNT_W(5)) bus1 ();

    rename_free_list #(.ARCH_REGS(32), .PHYS_REGS(64), .TAG_W(6)) u_dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
    rename_free_list #(.ARCH_REGS(32), .PHYS_REGS(48), .TAG_W(6)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

    logic [1:0] req [2];
    logic [1:0] cmt [2];
    logic [1:0] fv  [2];
    logic [5:0] ft  [2][2];
    logic       flush_d [2];

    assign bus0.alloc_req = req[0];  assign bus1.alloc_req = req[1];
    assign bus0.commit_alloc = cmt[0]; assign bus1.commit_alloc = cmt[1];
    assign bus0.free_valid = fv[0];  assign bus1.free_valid = fv[1];
    assign bus0.free_tag = {ft[0][1], ft[0][0]};
    assign bus1.free_tag = {ft[1][1], ft[1][0]};
    assign bus0.flush = flush_d[0];  assign bus1.flush = flush_d[1];

    logic       gnt_o [2];
    logic       stl_o [2];
    logic       err_o [2];
    logic [5:0] tag_o [2][2];
    logic [6:0] fc_o  [2];

    assign gnt_o[0] = bus0.alloc_grant; assign gnt_o[1] = bus1.alloc_grant;
    assign stl_o[0] = bus0.stall;       assign stl_o[1] = bus1.stall;
    assign err_o[0] = bus0.err;         assign err_o[1] = bus1.err;
    assign tag_o[0][0] = bus0.alloc_tag[0]; assign tag_o[0][1] = bus0.alloc_tag[1];
    assign tag_o[1][0] = bus1.alloc_tag[0]; assign tag_o[1][1] = bus1.alloc_tag[1];
    assign fc_o[0] = {1'b0, bus0.free_count};
    assign fc_o[1] = {2'b0, bus1.free_count};

    // Reference: fl = committed free list in allocation order, so = speculatively taken from its front.
    int fl   [2][$];
    int pool [2][$];
    int so   [2];
    bit m_err [2];

    int n_chk;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int depth(input int k);
        return (k == 0) ? 32 : 16;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input int exp);
        n_chk++;
        if (got !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic set_in(input int k, input logic [1:0] r, input logic [1:0] c, input logic [1:0] v,
                          input int t0, input int t1, input bit f);
        req[k] = r; cmt[k] = c; fv[k] = v;
        ft[k][0] = 6'(t0); ft[k][1] = 6'(t1);
        flush_d[k] = f;
    endtask

    task automatic idle();
        for (int k = 0; k < 2; k++) set_in(k, 2'b00, 2'b00, 2'b00, 0, 0, 1'b0);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            fl[k].delete();
            pool[k].delete();
            for (int i = 0; i < depth(k); i++) fl[k].push_back(32 + i);
            so[k] = 0;
            m_err[k] = 1'b0;
        end
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        #3;
        model_reset();
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Compare all outputs against the model, then advance the model across one clock edge.
    task automatic step();
        int  nreq [2];
        bit  eg [2];
        #2;
        for (int k = 0; k < 2; k++) begin
            int avail, e0, e1;
            bit es;
            nreq[k] = int'(req[k][0]) + int'(req[k][1]);
            avail = fl[k].size() - so[k];
            eg[k] = (nreq[k] != 0) && (avail >= nreq[k]) && !flush_d[k];
            es    = (nreq[k] != 0) && (avail <  nreq[k]) && !flush_d[k];
            e0 = 0; e1 = 0;
            if (eg[k]) begin
                if (req[k][0]) begin
                    e0 = fl[k][so[k]];
                    if (req[k][1]) e1 = fl[k][so[k] + 1];
                end else begin
                    e1 = fl[k][so[k]];
                end
            end
            check($sformatf("u%0d_grant", k), 32'(gnt_o[k]), int'(eg[k]));
            check($sformatf("u%0d_stall", k), 32'(stl_o[k]), int'(es));
            check($sformatf("u%0d_tag0", k), 32'(tag_o[k][0]), e0);
            check($sformatf("u%0d_tag1", k), 32'(tag_o[k][1]), e1);
            check($sformatf("u%0d_free_count", k), 32'(fc_o[k]), avail);
            check($sformatf("u%0d_err", k), 32'(err_o[k]), int'(m_err[k]));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            int nc, nf;
            nc = int'(cmt[k][0]) + int'(cmt[k][1]);
            nf = int'(fv[k][0]) + int'(fv[k][1]);
`ifdef RENAME_FREE_LIST_CHECK_EN
            if ((fl[k].size() + nf > depth(k)) || (nc > so[k]) ||
                (fv[k][0] && ft[k][0] == 6'd0) || (fv[k][1] && ft[k][1] == 6'd0) ||
                (fv[k] == 2'b11 && ft[k][0] == ft[k][1]))
                m_err[k] = 1'b1;
`endif
            if (eg[k]) so[k] += nreq[k];
            repeat (nc) if (fl[k].size() > 0) pool[k].push_back(fl[k].pop_front());
            so[k] -= nc;
            if (fv[k][0]) fl[k].push_back(int'(ft[k][0]));
            if (fv[k][1]) fl[k].push_back(int'(ft[k][1]));
            if (flush_d[k]) so[k] = 0;
        end
        #1;
    endtask

    // Allocate everything, commit it, return it in reversed order, and check it comes back in that order.
    task automatic rotate(input int k);
        int d;
        int exp_q [$];
        d = depth(k);
        for (int i = 0; i < d / 2; i++) begin idle(); set_in(k, 2'b11, 2'b00, 2'b00, 0, 0, 1'b0); step(); end
        for (int i = 0; i < d / 2; i++) begin idle(); set_in(k, 2'b00, 2'b11, 2'b00, 0, 0, 1'b0); step(); end
        for (int i = 0; i < d / 2; i++) begin
            int a, b;
            a = pool[k].pop_back();
            b = pool[k].pop_back();
            exp_q.push_back(a);
            exp_q.push_back(b);
            idle(); set_in(k, 2'b00, 2'b00, 2'b11, a, b, 1'b0); step();
        end
        for (int i = 0; i < d / 2; i++) begin
            idle(); set_in(k, 2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
            #2;
            check($sformatf("rot%0d_tag0", k), 32'(tag_o[k][0]), exp_q[2*i]);
            check($sformatf("rot%0d_tag1", k), 32'(tag_o[k][1]), exp_q[2*i+1]);
            step();
        end
        for (int i = 0; i < d / 2; i++) begin idle(); set_in(k, 2'b00, 2'b11, 2'b00, 0, 0, 1'b0); step(); end
    endtask

    initial begin
        int x;
        n_chk = 0;
        n_err = 0;
        reset_n = 1'b0;
        idle();
        #12;
        do_reset();

        // Reset state and first grant
        #2;
        check("rst_free_count0", 32'(fc_o[0]), 32);
        check("rst_free_count1", 32'(fc_o[1]), 16);
        check("rst_grant", 32'(gnt_o[0]), 0);
        check("rst_stall", 32'(stl_o[0]), 0);
        step();
        set_in(0, 2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
        #2;
        check("first_grant", 32'(gnt_o[0]), 1);
        check("first_tag0", 32'(tag_o[0][0]), 32);
        check("first_tag1", 32'(tag_o[0][1]), 33);
        step();
        #2;
        check("after_first_count", 32'(fc_o[0]), 30);
        step();
        for (int i = 2; i < 16; i++) begin
            if (i == 15) begin
                #2;
                check("last_tag0", 32'(tag_o[0][0]), 62);
                check("last_tag1", 32'(tag_o[0][1]), 63);
            end
            step();
        end
        set_in(0, 2'b01, 2'b00, 2'b00, 0, 0, 1'b0);
        #2;
        check("empty_stall", 32'(stl_o[0]), 1);
        check("empty_grant", 32'(gnt_o[0]), 0);
        check("empty_count", 32'(fc_o[0]), 0);
        step();

        // Freed tags are invisible to a same-cycle grant
        for (int i = 0; i < 16; i++) begin set_in(0, 2'b00, 2'b11, 2'b00, 0, 0, 1'b0); step(); end
        set_in(0, 2'b11, 2'b00, 2'b11, 5, 7, 1'b0);
        #2;
        check("free_same_cycle_stall", 32'(stl_o[0]), 1);
        step();
        set_in(0, 2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
        #2;
        check("freed_tag0", 32'(tag_o[0][0]), 5);
        check("freed_tag1", 32'(tag_o[0][1]), 7);
        step();
        set_in(0, 2'b00, 2'b11, 2'b00, 0, 0, 1'b0); step();

        // One entry left: no partial grant for two requests
        x = pool[0].pop_front();
        set_in(0, 2'b00, 2'b00, 2'b01, x, 0, 1'b0); step();
        set_in(0, 2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
        #2;
        check("one_left_stall", 32'(stl_o[0]), 1);
        check("one_left_grant", 32'(gnt_o[0]), 0);
        step();
        set_in(0, 2'b01, 2'b00, 2'b00, 0, 0, 1'b0);
        #2;
        check("one_left_single_tag", 32'(tag_o[0][0]), x);
        step();
        set_in(0, 2'b00, 2'b01, 2'b00, 0, 0, 1'b0); step();

        // Flush rollback, then commit+flush in the same cycle
        do_reset();
        for (int i = 0; i < 3; i++) begin set_in(0, 2'b11, 2'b00, 2'b00, 0, 0, 1'b0); step(); end
        set_in(0, 2'b00, 2'b11, 2'b00, 0, 0, 1'b0); step();
        set_in(0, 2'b01, 2'b00, 2'b00, 0, 0, 1'b1);
        #2;
        check("flush_no_grant", 32'(gnt_o[0]), 0);
        check("flush_no_stall", 32'(stl_o[0]), 0);
        step();
        set_in(0, 2'b01, 2'b00, 2'b00, 0, 0, 1'b0);
        #2;
        check("flush_count", 32'(fc_o[0]), 30);
        check("flush_regrant", 32'(tag_o[0][0]), 34);
        step();
        step();
        set_in(0, 2'b00, 2'b01, 2'b00, 0, 0, 1'b1); step();
        set_in(0, 2'b01, 2'b00, 2'b00, 0, 0, 1'b0);
        #2;
        check("commit_flush_count", 32'(fc_o[0]), 29);
        check("commit_flush_tag", 32'(tag_o[0][0]), 35);
        step();

        // Full rotation on both depths
        do_reset();
        rotate(0);
        rotate(1);

        // Randomized traffic on both instances
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                int nc, nf, t0, t1, mc, mf;
                logic [1:0] v;
                mc = (so[k] < 2) ? so[k] : 2;
                nc = $urandom_range(0, mc);
                mf = depth(k) - fl[k].size();
                if (mf > pool[k].size()) mf = pool[k].size();
                if (mf > 2) mf = 2;
                nf = $urandom_range(0, mf);
                t0 = 0; t1 = 0;
                v = 2'b00;
                if (nf == 2) begin
                    v = 2'b11; t0 = pool[k].pop_front(); t1 = pool[k].pop_front();
                end else if (nf == 1) begin
                    if ($urandom_range(0, 1) == 0) begin v = 2'b01; t0 = pool[k].pop_front(); end
                    else begin v = 2'b10; t1 = pool[k].pop_front(); end
                end
                set_in(k, 2'($urandom_range(0, 3)), (nc == 2) ? 2'b11 : (nc == 1) ? 2'b01 : 2'b00,
                       v, t0, t1, $urandom_range(0, 15) == 0);
            end
            step();
        end

`ifdef RENAME_FREE_LIST_CHECK_EN
        // Sticky error on a free into a full list
        do_reset();
        set_in(0, 2'b00, 2'b00, 2'b01, 40, 0, 1'b0); step();
        idle();
        #2;
        check("err_set", 32'(err_o[0]), 1);
        step(); step();
        #2;
        check("err_sticky", 32'(err_o[0]), 1);
        step();
        do_reset();
        #2;
        check("err_cleared", 32'(err_o[0]), 0);
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
